uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart.sv | 184 ++++++++++++++++++
 tb/tb_uart.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default clocking, bit-period derivation, FSM states
// and frame geometry used by both the transmitter and the receiver.
package uart_pkg;

    localparam int CLK_FREQ_DEFAULT  = 50_000_000;
    localparam int BAUD_RATE_DEFAULT = 115_200;
    localparam int DATA_BITS         = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Clock cycles per serial bit, integer-truncated.
    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts BAUD_DIV cycles per tick, optionally starting with a
// half period so the receiver lands on bit centres.
module uart_bit_timer #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= half ? HALF_RELOAD : FULL_RELOAD;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= FULL_RELOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: independent transmitter and receiver, each paced by its
// own bit timer. Reset is asynchronous and active-high on n_rst.
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
    parameter int BAUD_RATE = BAUD_RATE_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] uart_in,
    input  logic       uart_in_valid,
    output logic       rx_ready,
    output logic [7:0] uart_out,
    output logic       uart_out_valid,
    output logic       tx_ready,
    input  logic       RxD,
    output logic       TxD
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t tx_state, tx_next;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_idx;
    logic        tx_load, tx_tick, tx_accept, tx_line;

    assign tx_ready  = (tx_state == IDLE);
    assign tx_accept = tx_ready && uart_in_valid;

    uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (tx_state != IDLE),
        .load  (tx_load),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            tx_state <= IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_line = 1'b1;
        case (tx_state)
            IDLE: begin
                if (uart_in_valid) begin
                    tx_next = START;
                    tx_load = 1'b1;
                end
            end
            START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_next = DATA;
            end
            DATA: begin
                tx_line = tx_shift[0];
                if (tx_tick && tx_idx == LAST_BIT) tx_next = STOP;
            end
            STOP: begin
                if (tx_tick) tx_next = IDLE;
            end
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            tx_shift <= '0;
            tx_idx   <= '0;
        end else if (tx_accept) begin
            tx_shift <= uart_in;
            tx_idx   <= '0;
        end else if (tx_state == DATA && tx_tick) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= tx_idx + 3'd1;
        end
    end

    assign TxD = tx_line;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    uart_state_t rx_state, rx_next;
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev, rx_fall;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_idx;
    logic        rx_load, rx_tick, rx_done;

    // Synchronizer and edge history idle high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], RxD};
            rx_prev <= rx_s;
        end
    end

    assign rx_s     = rx_sync[1];
    assign rx_fall  = rx_prev && !rx_s;
    assign rx_ready = (rx_state == IDLE);
    assign rx_done  = (rx_state == STOP) && rx_tick && rx_s;

    uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (rx_state != IDLE),
        .load  (rx_load),
        .half  (1'b1),
        .tick  (rx_tick)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            rx_state <= IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        rx_load = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_fall) begin
                    rx_next = START;
                    rx_load = 1'b1;
                end
            end
            START: begin
                if (rx_tick) rx_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (rx_tick && rx_idx == LAST_BIT) rx_next = STOP;
            end
            STOP: begin
                if (rx_tick) rx_next = IDLE;
            end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            rx_shift <= '0;
            rx_idx   <= '0;
        end else if (rx_load) begin
            rx_idx   <= '0;
        end else if (rx_state == DATA && rx_tick) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
        end
    end

    // A frame with a low stop bit is dropped: no strobe and the last byte stays.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            uart_out       <= '0;
            uart_out_valid <= 1'b0;
        end else begin
            uart_out_valid <= rx_done;
            if (rx_done) uart_out <= rx_shift;
        end
    end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: loopback and directly driven serial frames,
// compared against a frame-level model of 8N1 serial timing.
module tb_uart;

    localparam int CLK_FREQ  = 3_200_000;
    localparam int BAUD_RATE = 100_000;
    localparam int D         = CLK_FREQ / BAUD_RATE;

    logic       clk;
    logic       n_rst;
    logic [7:0] uart_in;
    logic       uart_in_valid;
    logic       rx_ready;
    logic [7:0] uart_out;
    logic       uart_out_valid;
    logic       tx_ready;
    logic       rxd;
    logic       txd;
    logic       loopback;
    logic       tb_rxd;

    int vectors = 0;
    int errors  = 0;

    assign rxd = loopback ? txd : tb_rxd;

    uart #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .uart_in        (uart_in),
        .uart_in_valid  (uart_in_valid),
        .rx_ready       (rx_ready),
        .uart_out       (uart_out),
        .uart_out_valid (uart_out_valid),
        .tx_ready       (tx_ready),
        .RxD            (rxd),
        .TxD            (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive-side monitor: collects strobed bytes and flags strobes longer than a cycle.
    logic [7:0] rx_q[$];
    int         cyc        = 0;
    int         strobe_cyc = 0;
    int         start_cyc  = 0;
    int         dbl        = 0;
    logic       prev_v     = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (uart_out_valid === 1'b1) begin
            rx_q.push_back(uart_out);
            strobe_cyc = cyc;
            if (prev_v) dbl++;
        end
        prev_v = (uart_out_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line level of bit k of an 8N1 frame: start, 8 data bits LSB first, stop, then idle.
    function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int k);
        if (k == 0) return 1'b0;
        if (k >= 1 && k <= 8) return b[k-1];
        if (k == 9) return stop;
        return 1'b1;
    endfunction

    task automatic wait_tx_ready();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 20 * D) begin
            tick(1);
            n++;
        end
        if (tx_ready !== 1'b1) check("tx_ready_timeout", {31'b0, tx_ready}, 32'd1);
    endtask

    // Sends one byte, checks TxD at every bit centre and the busy duration.
    task automatic tx_frame(input logic [7:0] b, input bit inject);
        int busy = 0;
        bit done = 0;
        wait_tx_ready();
        uart_in       = b;
        uart_in_valid = 1'b1;
        tick(1);
        uart_in_valid = 1'b0;
        uart_in       = 8'($urandom);
        for (int c = 0; c < 12 * D && !done; c++) begin
            if (tx_ready === 1'b1) begin
                done = 1;
            end else begin
                if (c % D == D / 2) check("txd_bit", {31'b0, txd}, {31'b0, frame_bit(b, 1'b1, c / D)});
                busy++;
                if (inject && c == 3 * D) begin
                    uart_in       = 8'hFF;
                    uart_in_valid = 1'b1;
                    tick(1);
                    uart_in_valid = 1'b0;
                end else begin
                    tick(1);
                end
            end
        end
        check("tx_busy_cycles", busy, 10 * D);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            tb_rxd = frame_bit(b, stop, k);
            tick(D);
        end
        tb_rxd = 1'b1;
    endtask

    initial begin
        logic [7:0] b, b2;
        int lat;

        n_rst         = 1'b1;
        uart_in       = 8'h00;
        uart_in_valid = 1'b0;
        loopback      = 1'b1;
        tb_rxd        = 1'b1;

        // Reset state
        tick(3);
        check("rst_txd",      {31'b0, txd},            32'd1);
        check("rst_tx_ready", {31'b0, tx_ready},       32'd1);
        check("rst_rx_ready", {31'b0, rx_ready},       32'd1);
        check("rst_uart_out", {24'b0, uart_out},       32'h00);
        check("rst_valid",    {31'b0, uart_out_valid}, 32'd0);
        n_rst = 1'b0;
        tick(5);

        // Loopback of 0xA5 with a single-cycle request
        rx_q.delete();
        tx_frame(8'hA5, 1'b0);
        tick(20);
        check("a5_strobes", rx_q.size(), 1);
        check("a5_byte", (rx_q.size() > 0) ? {24'b0, rx_q[0]} : 32'hDEAD, 32'hA5);
        check("a5_uart_out", {24'b0, uart_out}, 32'hA5);

        // Random loopback bytes
        for (int i = 0; i < 100; i++) begin
            b = 8'($urandom_range(0, 254));
            rx_q.delete();
            tx_frame(b, 1'b0);
            tick(100);
            check("loop_strobes", rx_q.size(), 1);
            check("loop_byte", (rx_q.size() > 0) ? {24'b0, rx_q[0]} : 32'hDEAD, {24'b0, b});
        end

        // Request while busy is ignored
        rx_q.delete();
        tx_frame(8'h3C, 1'b1);
        tick(2 * D);
        check("busy_req_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("busy_req_txd",      {31'b0, txd},      32'd1);
        check("busy_req_strobes",  rx_q.size(), 1);
        check("busy_req_byte", (rx_q.size() > 0) ? {24'b0, rx_q[0]} : 32'hDEAD, 32'h3C);

        // Framing error: stop bit low
        loopback = 1'b0;
        tick(5);
        rx_q.delete();
        rx_frame(8'h55, 1'b0);
        tick(2 * D);
        check("ferr_strobes",  rx_q.size(), 0);
        check("ferr_uart_out", {24'b0, uart_out}, 32'h3C);
        check("ferr_rx_ready", {31'b0, rx_ready}, 32'd1);

        // Back-to-back directly driven frames, with latency bound on the second
        b  = 8'($urandom);
        b2 = 8'($urandom);
        rx_q.delete();
        rx_frame(b, 1'b1);
        rx_frame(b2, 1'b1);
        tick(D);
        check("b2b_strobes", rx_q.size(), 2);
        check("b2b_first",  (rx_q.size() > 0) ? {24'b0, rx_q[0]} : 32'hDEAD, {24'b0, b});
        check("b2b_second", (rx_q.size() > 1) ? {24'b0, rx_q[1]} : 32'hDEAD, {24'b0, b2});
        lat = strobe_cyc - start_cyc - 1;
        check("rx_latency_ok", {31'b0, (lat <= 9 * D + D / 2 + 4)}, 32'd1);

        // Short low glitch shorter than half a bit
        rx_q.delete();
        tb_rxd = 1'b0;
        tick(5);
        check("glitch_rx_busy", {31'b0, rx_ready}, 32'd0);
        tick(5);
        tb_rxd = 1'b1;
        tick(D);
        check("glitch_rx_ready", {31'b0, rx_ready}, 32'd1);
        check("glitch_strobes",  rx_q.size(), 0);

        // Reset in the middle of a loopback transmission
        loopback = 1'b1;
        tick(5);
        rx_q.delete();
        wait_tx_ready();
        uart_in       = 8'h81;
        uart_in_valid = 1'b1;
        tick(1);
        uart_in_valid = 1'b0;
        tick(4 * D);
        check("midrst_busy", {31'b0, tx_ready}, 32'd0);
        n_rst = 1'b1;
        #1;
        check("midrst_txd",      {31'b0, txd},            32'd1);
        check("midrst_tx_ready", {31'b0, tx_ready},       32'd1);
        check("midrst_rx_ready", {31'b0, rx_ready},       32'd1);
        check("midrst_uart_out", {24'b0, uart_out},       32'h00);
        check("midrst_valid",    {31'b0, uart_out_valid}, 32'd0);
        tick(3);
        n_rst = 1'b0;
        tick(3 * D);
        check("midrst_strobes", rx_q.size(), 0);
        tx_frame(8'h18, 1'b0);
        tick(20);
        check("post_rst_strobes", rx_q.size(), 1);
        check("post_rst_byte", (rx_q.size() > 0) ? {24'b0, rx_q[0]} : 32'hDEAD, 32'h18);

        check("single_cycle_strobes", dbl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
